// File: rtl/ugemm_pkg.sv
// Shared definitions for the uGEMM rate controller: FSM state encoding and
// the legal range of the RNG-to-accumulator pipeline latency.
package ugemm_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_FIN   = 3'd4
  } state_t;

  localparam int PIPE_LAT_MIN = 1;
  localparam int PIPE_LAT_MAX = 4;

endpackage

// File: rtl/rate_dly.sv
// Fixed-depth shift register that turns rng_en into acc_en. It shifts every
// cycle regardless of stall, so every issued step eventually reaches the
// accumulators. flush empties it so an aborted run leaves nothing in flight.
module rate_dly #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic din,
  output logic dout
);

  logic [DEPTH-1:0] stage_reg;
  logic [DEPTH-1:0] stage_next;

  // Stage 0 loads din; every later stage loads its predecessor.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
    if (gi == 0) begin : g_first
      assign stage_next[gi] = din;
    end else begin : g_rest
      assign stage_next[gi] = stage_reg[gi-1];
    end
  end

  // Shift every cycle; flush wins over shifting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_reg <= '0;
    end else if (flush) begin
      stage_reg <= '0;
    end else begin
      stage_reg <= stage_next;
    end
  end

  assign dout = stage_reg[DEPTH-1];

endmodule

// File: rtl/ugemm_rate_ctrl.sv
// Bitstream rate controller for a unary GEMM tile. Accepts one run request,
// clears the Sobol RNGs, issues 2^L step enables (stallable by hold), waits
// for the accumulator pipeline to drain, then pulses done.
module ugemm_rate_ctrl
  import ugemm_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int LOGWIDTH = 3,
  parameter int PIPE_LAT = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_valid,
  output logic                start_ready,
  input  logic [LOGWIDTH:0]   len_log,
  input  logic                hold,
  input  logic                abort,
  output logic                rng_clr,
  output logic                rng_en,
  output logic                acc_en,
  output logic [WIDTH-1:0]    cyc_cnt,
  output logic                busy,
  output logic                done
);

  if (PIPE_LAT < PIPE_LAT_MIN || PIPE_LAT > PIPE_LAT_MAX) begin : g_bad_pipe_lat
    $error("ugemm_rate_ctrl: PIPE_LAT out of range");
  end

  localparam logic [LOGWIDTH:0] WIDTH_L    = (LOGWIDTH+1)'(WIDTH);
  localparam logic [1:0]        DRAIN_LAST = 2'(PIPE_LAT - 1);

  state_t              state_reg, state_next;
  logic [WIDTH-1:0]    cyc_cnt_reg;
  logic [WIDTH-1:0]    last_reg;
  logic [WIDTH-1:0]    last_next;
  logic [1:0]          drain_cnt_reg;
  logic [LOGWIDTH:0]   len_eff;
  logic                accept;
  logic                abort_act;
  logic                step;

  // Clamp the requested length to what the counter can express.
  assign len_eff = (len_log > WIDTH_L) ? WIDTH_L : len_log;

  // Index of the final step, N-1 = 2^L - 1, built as a thermometer mask so
  // L = WIDTH yields all ones without needing a WIDTH+1-bit intermediate.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_last
    assign last_next[gi] = (len_eff > (LOGWIDTH+1)'(gi));
  end

  assign accept    = (state_reg == S_IDLE) && start_valid;
  assign abort_act = (state_reg != S_IDLE) && abort;
  // Stall and abort gate the step in the same cycle so the counter never
  // advances on a cycle that does not actually step the RNGs.
  assign step      = (state_reg == S_RUN) && !hold && !abort;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state decode; abort overrides every non-idle transition.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (start_valid) state_next = S_CLEAR;
      S_CLEAR: state_next = S_RUN;
      S_RUN:   if (step && (cyc_cnt_reg == last_reg)) state_next = S_DRAIN;
      S_DRAIN: if (drain_cnt_reg == DRAIN_LAST) state_next = S_FIN;
      S_FIN:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    if (abort_act) begin
      state_next = S_IDLE;
    end
  end

  // Step counter (wraps naturally) and latched final-step index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_cnt_reg <= '0;
      last_reg    <= '0;
    end else if (accept) begin
      cyc_cnt_reg <= '0;
      last_reg    <= last_next;
    end else if (step) begin
      cyc_cnt_reg <= cyc_cnt_reg + 1'b1;
    end
  end

  // Counts cycles spent in DRAIN; held at zero elsewhere.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drain_cnt_reg <= '0;
    end else if (state_reg == S_DRAIN) begin
      drain_cnt_reg <= drain_cnt_reg + 1'b1;
    end else begin
      drain_cnt_reg <= '0;
    end
  end

  rate_dly #(
    .DEPTH (PIPE_LAT)
  ) u_acc_dly (
    .clk   (clk),
    .rst   (rst),
    .flush (abort_act),
    .din   (step),
    .dout  (acc_en)
  );

  assign start_ready = (state_reg == S_IDLE);
  assign busy        = (state_reg != S_IDLE);
  assign rng_clr     = (state_reg == S_CLEAR);
  assign done        = (state_reg == S_FIN);
  assign rng_en      = step;
  assign cyc_cnt     = cyc_cnt_reg;

endmodule

// File: tb/tb_ugemm_rate_ctrl.sv
// Scoreboard bench for ugemm_rate_ctrl: each run pushes its expected totals,
// a negedge monitor tallies DUT activity per run and compares on run end.
module tb_ugemm_rate_ctrl;

  localparam int WIDTH    = 8;
  localparam int LOGWIDTH = 3;
  localparam int PIPE_LAT = 2;
  localparam int MAX_CYC  = 600;

  typedef struct {
    int rng;
    int acc;
    int clr;
    int dn;
    int cyc;
    int lat;
  } exp_t;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                start_valid = 1'b0;
  logic                start_ready;
  logic [LOGWIDTH:0]   len_log = '0;
  logic                hold = 1'b0;
  logic                abort = 1'b0;
  logic                rng_clr;
  logic                rng_en;
  logic                acc_en;
  logic [WIDTH-1:0]    cyc_cnt;
  logic                busy;
  logic                done;

  int   checks = 0;
  int   errors = 0;
  int   stray_done = 0;
  exp_t exp_q[$];

  ugemm_rate_ctrl #(
    .WIDTH    (WIDTH),
    .LOGWIDTH (LOGWIDTH),
    .PIPE_LAT (PIPE_LAT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .len_log     (len_log),
    .hold        (hold),
    .abort       (abort),
    .rng_clr     (rng_clr),
    .rng_en      (rng_en),
    .acc_en      (acc_en),
    .cyc_cnt     (cyc_cnt),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rng_en"},      int'(rng_en), 0);
    chk({tag, "_acc_en"},      int'(acc_en), 0);
    chk({tag, "_rng_clr"},     int'(rng_clr), 0);
    chk({tag, "_done"},        int'(done), 0);
    chk({tag, "_busy"},        int'(busy), 0);
    chk({tag, "_start_ready"}, int'(start_ready), 1);
    chk({tag, "_cyc_cnt"},     int'(cyc_cnt), 0);
  endtask

  // Issue one run. Called #1 after a rising edge while the DUT is idle.
  // Cycle index k counts cycles after the accept edge (k=1 is CLEAR).
  // hs..he: hold window; ab_at / rst_at: cycle to assert abort / rst (0 = never).
  task automatic do_run(input int ll, input int hs, input int he, input int ab_at,
                        input int rst_at, input bit ab_with_start, input exp_t e);
    int  k;
    bit  fin;
    exp_q.push_back(e);
    chk("start_ready_before_run", int'(start_ready), 1);
    start_valid = 1'b1;
    len_log     = ll[LOGWIDTH:0];
    abort       = ab_with_start;
    @(posedge clk); #1;
    start_valid = 1'b0;
    abort       = 1'b0;
    k   = 1;
    fin = 1'b0;
    while (!fin) begin
      hold  = (k >= hs) && (k <= he);
      abort = (k == ab_at);
      if (k == rst_at) rst = 1'b1;
      @(posedge clk); #1;
      if (!busy) begin
        fin = 1'b1;
      end else if (k >= MAX_CYC) begin
        checks++;
        errors++;
        $display("FAIL run_timeout: busy still 1 after %0d cycles, expected 0", k);
        fin = 1'b1;
      end
      k++;
    end
    hold  = 1'b0;
    abort = 1'b0;
  endtask

  // Monitor: tallies per-run activity on the falling edge and checks against
  // the scoreboard entry when busy drops.
  initial begin
    bit   in_run;
    int   n_rng, n_acc, n_clr, n_done, idx, lat, run_no;
    exp_t e;
    in_run = 1'b0;
    run_no = 0;
    n_rng = 0; n_acc = 0; n_clr = 0; n_done = 0; idx = 0; lat = 0;
    forever begin
      @(negedge clk);
      if (in_run) begin
        idx++;
        n_rng  += int'(rng_en);
        n_acc  += int'(acc_en);
        n_clr  += int'(rng_clr);
        n_done += int'(done);
        if (done && lat == 0) lat = idx;
        if (!busy) begin
          in_run = 1'b0;
          run_no++;
          $display("run %0d: rng_en=%0d acc_en=%0d rng_clr=%0d done=%0d cyc_cnt=%0d done_lat=%0d",
                   run_no, n_rng, n_acc, n_clr, n_done, cyc_cnt, lat);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_underflow: run %0d ended with no expected entry", run_no);
          end else begin
            e = exp_q.pop_front();
            chk($sformatf("run%0d_rng_en_count", run_no), n_rng, e.rng);
            chk($sformatf("run%0d_acc_en_count", run_no), n_acc, e.acc);
            chk($sformatf("run%0d_rng_clr_count", run_no), n_clr, e.clr);
            chk($sformatf("run%0d_done_count", run_no), n_done, e.dn);
            chk($sformatf("run%0d_cyc_cnt_end", run_no), int'(cyc_cnt), e.cyc);
            if (e.dn != 0) chk($sformatf("run%0d_done_latency", run_no), lat, e.lat);
          end
        end
      end
      if (!in_run && done) stray_done++;
      if (!in_run && start_valid && start_ready && !rst) begin
        in_run = 1'b1;
        n_rng = 0; n_acc = 0; n_clr = 0; n_done = 0; idx = 0; lat = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // len 8, first accept right after reset release.
    do_run(3, 0, -1, 0, 0, 1'b0, '{8, 8, 1, 1, 8, 12});
    // Full length: counter wraps to 0.
    do_run(8, 0, -1, 0, 0, 1'b0, '{256, 256, 1, 1, 0, 260});
    // 3 stall cycles mid-run.
    do_run(4, 4, 6, 0, 0, 1'b0, '{16, 16, 1, 1, 16, 23});
    // Abort on the 5th RUN cycle: 4 steps issued, 3 reach the accumulator.
    do_run(4, 0, -1, 6, 0, 1'b0, '{4, 3, 1, 0, 4, 0});
    // Single-step run, started the cycle after the abort.
    do_run(0, 0, -1, 0, 0, 1'b0, '{1, 1, 1, 1, 1, 5});
    // Oversized request clamps to 256 steps.
    do_run(9, 0, -1, 0, 0, 1'b0, '{256, 256, 1, 1, 0, 260});
    // Reset during the first DRAIN cycle.
    do_run(2, 0, -1, 0, 6, 1'b0, '{4, 2, 1, 0, 0, 0});
    check_reset_outputs("mid_drain_reset");
    @(posedge clk); #1;
    rst = 1'b0;
    chk("start_ready_after_release", int'(start_ready), 1);
    // Abort alongside start in IDLE is ignored; hold in CLEAR is ignored.
    do_run(1, 1, 1, 0, 0, 1'b1, '{2, 2, 1, 1, 2, 6});

    repeat (5) @(posedge clk);
    #1;
    chk("scoreboard_empty", exp_q.size(), 0);
    chk("stray_done", stray_done, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
